pipe_alu: RTL
=============

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 4..64.
REQ-002 Derived constant SW = clog2(WIDTH)+1: width of the shift counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion, independent of clk.
REQ-005 in_valid  input  1  request present on alu_input_a, alu_input_b, alu_opcode.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alu_input_a  input  WIDTH  first operand, unsigned unless stated.
REQ-008 alu_input_b  input  WIDTH  second operand, or shift amount.
REQ-009 alu_opcode  input  3  000 AND, 001 ADD, 010 XOR, 011 SLT, 100 SLL, 101 SRL, 110 SNE, 111 OVF.
REQ-010 out_valid  output  1  alu_out and flags hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 alu_out  output  WIDTH  registered result.
REQ-013 zero  output  1  1 when alu_out == 0.
REQ-014 carry  output  1  ADD carry-out; 0 for all other opcodes.
REQ-015 overflow  output  1  signed two's-complement overflow of a+b for ADD and OVF; 0 otherwise.

Function
REQ-016 The FSM SHALL have three states, IDLE, SHIFT and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 A request SHALL be accepted on a rising edge where in_valid & in_ready; operands and opcode are captured on that edge, and later input changes have no effect.
REQ-018 For a non-shift opcode, or for a shift with count 0, the accepting edge SHALL load the result and flags and enter DONE, so out_valid rises 1 cycle after acceptance.
REQ-019 Shift count k = min(alu_input_b, WIDTH); for SLL or SRL with k>0, the accepting edge SHALL load acc=a and cnt=k and enter SHIFT.
REQ-020 Each SHIFT edge SHALL shift acc by one bit (SLL left, SRL right, zero fill) and decrement cnt; the edge on which cnt==1 SHALL write the final acc to alu_out and enter DONE, so out_valid rises k+1 cycles after acceptance.
REQ-021 A shift with alu_input_b >= WIDTH SHALL produce 0 after exactly WIDTH SHIFT cycles.
REQ-022 The combinational ops SHALL produce the following, all arithmetic modulo 2^WIDTH:
  - AND: a&b.
  - ADD: a+b; carry = bit WIDTH of the full sum.
  - XOR: a^b.
  - SLT: 1 if a<b unsigned, else 0, zero-extended to WIDTH.
  - SNE: 1 if a!=b, else 0, zero-extended to WIDTH.
REQ-023 OVF SHALL output 1 (zero-extended) iff a[MSB]==b[MSB] and sum[MSB]!=a[MSB], where sum = a+b truncated to WIDTH; the overflow flag is set identically.
REQ-024 zero SHALL be computed from the value being loaded into alu_out, so it is valid whenever out_valid=1.
REQ-025 In DONE, alu_out and all flags SHALL remain stable until out_ready=1; on that edge the FSM enters IDLE.
REQ-026 No request SHALL be accepted on the same edge that a result is retired; the minimum issue interval is 2 cycles for combinational ops and k+2 cycles for shifts.
REQ-027 in_valid while the block is busy SHALL be ignored and SHALL NOT be queued.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 Asserting reset SHALL force state=IDLE, alu_out=0, carry=0, overflow=0, cnt=0 and acc=0; zero therefore reads 1 and out_valid reads 0.
REQ-030 Reset asserted during SHIFT or DONE SHALL discard the in-flight operation with no result delivered; the first rising edge after deassertion may accept a new request.

Verification
REQ-031 WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> alu_out=0x00, zero=1, carry=1, overflow=0, out_valid 1 cycle after acceptance, high for exactly 1 cycle.
REQ-032 WIDTH=8, OVF a=0x7F b=0x01 -> alu_out=0x01, overflow=1; OVF a=0x80 b=0x7F -> alu_out=0x00, overflow=0.
REQ-033 WIDTH=8, SLL a=0x03 b=3 -> out_valid 4 cycles after acceptance, alu_out=0x18; SRL a=0xF0 b=9 -> 0x00 after 8 SHIFT cycles; SLL b=0 -> a after 1 cycle.
REQ-034 Backpressure: SLT a=2 b=5 with out_ready=0 for 5 cycles -> alu_out=0x01 stable and in_ready=0 throughout; a second in_valid during the hold is dropped; out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-shift: SLL k=6, assert reset asynchronously after 2 SHIFT cycles -> out_valid=0 and alu_out=0 immediately, in_ready=1 after deassertion, no stale result.
REQ-036 Random regression at WIDTH=8, 16 and 32 -> every result matches a reference model for all opcodes, including edge operands 0, all-ones and MSB-only.

Source files
------------

// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU with a bit-serial shifter.
// Combinational opcodes complete on the accepting edge; SLL/SRL shift one
// bit per cycle. The result is held in DONE until the consumer takes it.
module pipe_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_input_a,
  input  logic [WIDTH-1:0] alu_input_b,
  input  logic [2:0]       alu_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [SW-1:0]    WIDTH_S = SW'(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SNE = 3'b110;
  localparam logic [2:0] OP_OVF = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [SW-1:0]        cnt;
  logic                 shift_right;

  logic [SW-1:0]        shift_k;
  logic                 is_shift;
  logic [WIDTH-1:0]     eval_res;
  logic                 eval_c;
  logic                 eval_v;
  logic [WIDTH-1:0]     acc_next;

  // Single-cycle result as {overflow, carry, result}. Shift opcodes only
  // reach this path with a zero count, where the result is the operand.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic               [WIDTH:0]   sum;
    logic signed        [WIDTH-1:0] a_s;
    logic signed        [WIDTH-1:0] b_s;
    logic signed        [WIDTH-1:0] s_s;
    logic                           ovf;
    sum = {1'b0, a} + {1'b0, b};
    a_s = a;
    b_s = b;
    s_s = sum[WIDTH-1:0];
    // Two's-complement overflow: like-signed operands, differently signed sum.
    ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (s_s[WIDTH-1] != a_s[WIDTH-1]);
    case (op)
      OP_AND:  alu_eval = {2'b00, a & b};
      OP_ADD:  alu_eval = {ovf, sum[WIDTH], sum[WIDTH-1:0]};
      OP_XOR:  alu_eval = {2'b00, a ^ b};
      OP_SLT:  alu_eval = {2'b00, WIDTH'(a < b)};
      OP_SNE:  alu_eval = {2'b00, WIDTH'(a != b)};
      OP_OVF:  alu_eval = {ovf, 1'b0, WIDTH'(ovf)};
      default: alu_eval = {2'b00, a};
    endcase
  endfunction

  // Shift count saturates at WIDTH so oversize amounts drain to zero.
  always_comb begin
    is_shift = (alu_opcode == OP_SLL) || (alu_opcode == OP_SRL);
    shift_k  = (alu_input_b >= WIDTH_V) ? WIDTH_S : alu_input_b[SW-1:0];
  end

  assign {eval_v, eval_c, eval_res} = alu_eval(alu_input_a, alu_input_b, alu_opcode);

  // One-bit zero-fill step of the serial shifter.
  always_comb begin
    acc_next = shift_right ? (acc >> 1) : (acc << 1);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM plus result/flag registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      shift_right <= 1'b0;
      alu_out     <= '0;
      zero        <= 1'b1;
      carry       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shift_k != '0)) begin
              acc         <= alu_input_a;
              cnt         <= shift_k;
              shift_right <= (alu_opcode == OP_SRL);
              state       <= SHIFT;
            end else begin
              alu_out  <= eval_res;
              zero     <= (eval_res == '0);
              carry    <= eval_c;
              overflow <= eval_v;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            alu_out  <= acc_next;
            zero     <= (acc_next == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
